iob_dma_burst: RTL and testbench
================================

# iob_dma_burst

Descriptor-driven burst generator that sits directly upstream of the IOb-to-AXI bridge. It takes a transfer request (start address, word count, direction) and splits it into AXI bursts. Each burst is capped at MAX_BEATS and never crosses a 4 KB boundary. For each burst it drives the bridge's control port (`run` / `direction` / `length`) and then issues one native access per beat. Write data is sourced from a valid/ready input stream; read data is delivered to a valid/ready output stream.

## Interface
- ADDR_W, 32, byte-address width; also drives the bridge native address.
- DATA_W, 32, data width; must be a power of 2 and ≥ 8.
- CNT_W, 16, width of the descriptor word count.
- MAX_BEATS, 16, maximum beats per burst; power of 2, range 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  descriptor strobe; sampled only when idle.
- dir  in  1  1 = write to memory, 0 = read from memory.
- addr  in  ADDR_W  start byte address, aligned to DATA_W/8.
- nwords  in  CNT_W  number of words to transfer.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a transfer.
- error  out  1  sticky OR of `iob_error`; cleared on an accepted start.
- in_valid / in_data[DATA_W] / in_ready  in / in / out  write-data stream.
- out_valid / out_data[DATA_W] / out_ready  out / out / in  read-data stream.
- iob_run  out  1  bridge run strobe.
- iob_direction  out  1  bridge direction.
- iob_length  out  8  burst length, encoded as beats−1.
- iob_ready  in  1  bridge idle.
- iob_error  in  1  bridge error.
- m_valid  out  1  native request valid.
- m_addr  out  ADDR_W  native address.
- m_wdata  out  DATA_W  native write data.
- m_wstrb  out  DATA_W/8  native write strobe.
- m_rdata  in  DATA_W  native read data.
- m_ready  in  1  native ready.

## Operation
State machine: IDLE → BURST → XFER → (BURST | DRAIN) → IDLE.

- **IDLE**
  - `start` with nwords ≠ 0: latch cur_addr = addr, remaining = nwords, dir; clear error; go to BURST.
  - `start` with nwords = 0: pulse done next cycle; stay in IDLE.
  - `start` in any other state is ignored.
- **BURST**
  - beats = min(remaining, MAX_BEATS, (4096 − cur_addr[11:0]) / (DATA_W/8)).
  - When iob_ready = 1: assert iob_run for exactly one cycle, with iob_length = beats−1 and iob_direction = dir; load beat_cnt = beats; go to XFER.
- **XFER, write**
  - m_valid = in_valid; m_wdata = in_data; m_wstrb = all ones; in_ready = m_ready.
- **XFER, read**
  - m_wstrb = 0.
  - m_valid = 1 while the 1-entry output register is empty, or is full and out_ready = 1.
  - On m_valid & m_ready, load out_data ← m_rdata and set out_valid.
  - out_valid clears on out_ready when no new beat is loaded in the same cycle.
- **Per accepted beat (m_valid & m_ready)**
  - m_addr = cur_addr.
  - cur_addr += DATA_W/8; remaining −= 1; beat_cnt −= 1.
- **Leaving XFER**
  - Last beat of a burst: go to BURST if remaining ≠ 0, else to DRAIN.
- **DRAIN**
  - Wait for iob_ready = 1 and out_valid = 0, then pulse done and go to IDLE.
- **Errors**
  - iob_error does not abort the transfer; error latches it until the next accepted start.
- **Reset**
  - rst at any time returns to IDLE and discards all in-flight state.
  - The bridge is reset by the same rst.

## Timing
- Reset values: busy, done, error, iob_run, iob_direction, m_valid, in_ready, out_valid = 0; iob_length, m_addr, out_data = 0.
- Start to first iob_run: 1 cycle minimum (start cycle → BURST); the run is issued in the first BURST cycle with iob_ready = 1.
- iob_run to first m_valid: the next cycle.
- Throughput: 1 beat per cycle when in_valid / out_ready and m_ready are held high.
- Burst gap: at least 1 cycle in BURST between bursts.
- done: pulses 1 cycle after the DRAIN condition is met; busy falls in the same cycle done is high.
- iob_run: never asserted while iob_ready = 0; never asserted twice for the same burst.
- Beat count limit: m_valid & m_ready never occurs more than `beats` times per run.

## Test plan
- **Write, single burst:** addr = 0x100, nwords = 4, dir = 1, in_valid always 1, m_ready always 1 → one iob_run with length = 3; m_addr = 0x100, 0x104, 0x108, 0x10C; done 1 cycle after DRAIN.
- **Multi-burst and 4 KB split:** addr = 0x0FF8, nwords = 40, MAX_BEATS = 16 → bursts of 2, 16, 16, 6 beats; lengths 1, 15, 15, 5; second burst starts at m_addr 0x1000.
- **Read with backpressure:** nwords = 8, dir = 0, out_ready toggling 1/0 → m_valid drops while the output register is full and out_ready = 0; all 8 m_rdata values appear on out_data in order with none lost.
- **Write stream stall:** in_valid low for 5 cycles mid-burst → m_valid low and no address advance; transfer resumes and completes with the correct beat count.
- **Edge cases:** nwords = 0 → done pulse, no iob_run. start while busy → ignored. iob_error pulse → error stays 1 until the next start. rst mid-XFER → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/iob_dma_burst.sv
// ============================================================================
// Module   : iob_dma_burst
// Purpose  : Splits a DMA descriptor into 4 KB-safe AXI bursts for the
//            IOb-to-AXI bridge and moves data over native beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iob_dma_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dir,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [CNT_W-1:0]    nwords,
  output logic                busy,
  output logic                done,
  output logic                error,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic                iob_run,
  output logic                iob_direction,
  output logic [7:0]          iob_length,
  input  logic                iob_ready,
  input  logic                iob_error,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int BW    = 9;
  localparam int CW    = (CNT_W > 13) ? CNT_W : 13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_XFER  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic [BW-1:0]     beat_cnt;
  logic              dir_q;

  logic [12:0]       room;
  logic [BW-1:0]     cap;
  logic [BW-1:0]     beats;
  logic              wr_xfer;
  logic              rd_xfer;
  logic              beat;

  // Burst size: smallest of words left, MAX_BEATS and words to the next 4 KB page.
  always_comb begin
    room  = (13'h1000 - {1'b0, cur_addr[11:0]}) >> SHIFT;
    cap   = (CW'(room) < CW'(MAX_BEATS)) ? BW'(room) : BW'(MAX_BEATS);
    beats = (CW'(remaining) < CW'(cap)) ? BW'(remaining) : cap;
  end

  assign wr_xfer = (state == S_XFER) && dir_q;
  assign rd_xfer = (state == S_XFER) && !dir_q;

  assign m_valid  = wr_xfer ? in_valid : (rd_xfer ? (!out_valid || out_ready) : 1'b0);
  assign beat     = m_valid && m_ready;
  assign in_ready = wr_xfer && m_ready;
  assign m_addr   = cur_addr;
  assign m_wdata  = wr_xfer ? in_data : '0;
  assign m_wstrb  = wr_xfer ? '1 : '0;

  // Run must appear in the BURST cycle itself so the first beat can follow next cycle.
  assign iob_run       = (state == S_BURST) && iob_ready;
  assign iob_direction = (state != S_IDLE) && dir_q;
  assign iob_length    = (state == S_BURST) ? 8'(beats - BW'(1)) : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      dir_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      if (iob_error) begin
        error <= 1'b1;
      end

      if (rd_xfer && beat) begin
        out_data  <= m_rdata;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (nwords != '0) begin
              cur_addr  <= addr;
              remaining <= nwords;
              dir_q     <= dir;
              busy      <= 1'b1;
              state     <= S_BURST;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_BURST: begin
          if (iob_ready) begin
            beat_cnt <= beats;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (beat) begin
            cur_addr  <= cur_addr + ADDR_W'(BYTES);
            remaining <= remaining - CNT_W'(1);
            beat_cnt  <= beat_cnt - BW'(1);
            if (beat_cnt == BW'(1)) begin
              state <= (remaining != CNT_W'(1)) ? S_BURST : S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Hold done until the bridge has retired the last burst and the read buffer is empty.
          if (iob_ready && !out_valid) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_dma_burst.sv
// ============================================================================
// Module   : tb_iob_dma_burst
// Purpose  : Directed self-checking bench for iob_dma_burst.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iob_dma_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [31:0] addr = '0;
  logic [15:0] nwords = '0;
  logic        busy, done, error;
  logic        in_valid = 1'b0;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        iob_run, iob_direction;
  logic [7:0]  iob_length;
  logic        iob_ready = 1'b1;
  logic        iob_error = 1'b0;
  logic        m_valid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] wcnt = '0;

  iob_dma_burst dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .addr(addr), .nwords(nwords),
    .busy(busy), .done(done), .error(error),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .iob_run(iob_run), .iob_direction(iob_direction), .iob_length(iob_length),
    .iob_ready(iob_ready), .iob_error(iob_error),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (in_valid && in_ready) wcnt <= wcnt + 1;
  assign in_data = 32'hD000_0000 + wcnt;
  assign m_rdata = m_addr ^ 32'h5A5A_0000;

  // Event recorder, sampled mid-cycle.
  logic [7:0]  run_len[$];
  logic        run_dir[$];
  int          run_cyc[$];
  int          run_beats[$];
  logic [31:0] beat_addr[$];
  logic [31:0] beat_data[$];
  logic [3:0]  beat_strb[$];
  int          beat_cyc[$];
  logic [31:0] outs[$];
  int cur_beats, done_cnt, done_cyc, run_bad, bp_bad, stall_seen, busy_bad;

  always @(negedge clk) begin
    if (!rst) begin
      if (iob_run) begin
        if (!iob_ready) run_bad++;
        if (run_len.size() > 0) run_beats.push_back(cur_beats);
        cur_beats = 0;
        run_len.push_back(iob_length);
        run_dir.push_back(iob_direction);
        run_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        beat_addr.push_back(m_addr);
        beat_data.push_back(m_wdata);
        beat_strb.push_back(m_wstrb);
        beat_cyc.push_back(cyc);
        cur_beats++;
      end
      if (out_valid && out_ready) outs.push_back(out_data);
      if (out_valid && !out_ready) begin
        stall_seen++;
        if (m_valid) bp_bad++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) busy_bad++;
        if (run_len.size() > 0) run_beats.push_back(cur_beats);
        cur_beats = 0;
      end
    end
  end

  task automatic clear_mon();
    run_len.delete(); run_dir.delete(); run_cyc.delete(); run_beats.delete();
    beat_addr.delete(); beat_data.delete(); beat_strb.delete(); beat_cyc.delete();
    outs.delete();
    cur_beats = 0; done_cnt = 0; done_cyc = 0; run_bad = 0; bp_bad = 0;
    stall_seen = 0; busy_bad = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic d, input logic [31:0] a, input logic [15:0] n,
                          output int s);
    step();
    start = 1'b1; dir = d; addr = a; nwords = n;
    s = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit toggle, input string nm);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) return;
      step();
      if (toggle) out_ready = ~out_ready;
    end
    checks++; errors++;
    $display("FAIL %s_timeout: done not seen, required within %0d cycles", nm, maxc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, done, error, iob_run, iob_direction, m_valid, in_ready, out_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {busy, done, error, iob_run, iob_direction, m_valid, in_ready, out_valid});
    end
    checks++;
    if (iob_length !== 8'd0 || m_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_len_addr: got len=%h addr=%h required 0/0", iob_length, m_addr);
    end
    checks++;
    if (out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_out_data: got %h required 0", out_data);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_write_single();
    int s;
    logic [31:0] w0;
    clear_mon();
    in_valid = 1'b1; m_ready = 1'b1; iob_ready = 1'b1; out_ready = 1'b0;
    w0 = wcnt;
    do_start(1'b1, 32'h100, 16'd4, s);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_busy_rise: got %b required 1", busy);
    end
    wait_done(50, 1'b0, "wr_single");
    checks++;
    if (run_len.size() != 1 || run_len[0] !== 8'd3 || run_dir[0] !== 1'b1) begin
      errors++;
      $display("FAIL wr_run: got runs=%0d len=%h required 1 run len 03 dir 1",
               run_len.size(), (run_len.size() > 0) ? run_len[0] : 8'hxx);
    end
    checks++;
    if (run_cyc.size() != 1 || run_cyc[0] - s != 1) begin
      errors++;
      $display("FAIL wr_start_to_run: got %0d cycles required 1",
               (run_cyc.size() > 0) ? run_cyc[0] - s : -1);
    end
    checks++;
    if (beat_addr.size() != 4) begin
      errors++;
      $display("FAIL wr_beat_count: got %0d required 4", beat_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_addr[i] !== 32'h100 + 32'(4 * i) || beat_data[i] !== 32'hD000_0000 + w0 + 32'(i)
            || beat_strb[i] !== 4'hF) begin
          errors++;
          $display("FAIL wr_beat%0d: got addr=%h data=%h strb=%h required %h/%h/f", i,
                   beat_addr[i], beat_data[i], beat_strb[i], 32'h100 + 32'(4 * i),
                   32'hD000_0000 + w0 + 32'(i));
        end
      end
      checks++;
      if (beat_cyc[0] - run_cyc[0] != 1 || done_cyc - beat_cyc[3] != 2) begin
        errors++;
        $display("FAIL wr_latency: got run->beat=%0d lastbeat->done=%0d required 1/2",
                 beat_cyc[0] - run_cyc[0], done_cyc - beat_cyc[3]);
      end
    end
    checks++;
    if (done_cnt != 1 || busy_bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_busy: got done=%0d busy_with_done=%0d busy=%b required 1/0/0",
               done_cnt, busy_bad, busy);
    end
  endtask

  task automatic test_multi_burst();
    int s;
    logic [7:0] exp_len[4];
    int exp_beats[4];
    exp_len = '{8'd1, 8'd15, 8'd15, 8'd5};
    exp_beats = '{2, 16, 16, 6};
    clear_mon();
    in_valid = 1'b1; iob_ready = 1'b0;
    do_start(1'b1, 32'h0FF8, 16'd40, s);
    step(); step(); step();
    iob_ready = 1'b1;
    wait_done(200, 1'b0, "multi");
    checks++;
    if (run_bad != 0 || run_cyc.size() == 0 || run_cyc[0] - s != 4) begin
      errors++;
      $display("FAIL multi_run_wait: got bad=%0d delay=%0d required 0/4", run_bad,
               (run_cyc.size() > 0) ? run_cyc[0] - s : -1);
    end
    checks++;
    if (run_len.size() != 4 || run_beats.size() != 4) begin
      errors++;
      $display("FAIL multi_runs: got %0d runs %0d counts required 4/4",
               run_len.size(), run_beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (run_len[i] !== exp_len[i] || run_beats[i] != exp_beats[i]) begin
          errors++;
          $display("FAIL multi_burst%0d: got len=%h beats=%0d required %h/%0d", i,
                   run_len[i], run_beats[i], exp_len[i], exp_beats[i]);
        end
      end
    end
    checks++;
    if (beat_addr.size() != 40) begin
      errors++;
      $display("FAIL multi_beats: got %0d required 40", beat_addr.size());
    end else begin
      checks++;
      if (beat_addr[2] !== 32'h1000 || beat_addr[39] !== 32'h1094) begin
        errors++;
        $display("FAIL multi_addr: got [2]=%h [39]=%h required 1000/1094",
                 beat_addr[2], beat_addr[39]);
      end
      checks++;
      if (beat_cyc[2] - beat_cyc[1] != 2) begin
        errors++;
        $display("FAIL multi_gap: got %0d required 2", beat_cyc[2] - beat_cyc[1]);
      end
    end
  endtask

  task automatic test_read_backpressure();
    int s;
    clear_mon();
    in_valid = 1'b0; out_ready = 1'b1; iob_ready = 1'b1;
    do_start(1'b0, 32'h200, 16'd8, s);
    wait_done(100, 1'b1, "rd_bp");
    checks++;
    if (run_len.size() != 1 || run_len[0] !== 8'd7 || run_dir[0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_run: got runs=%0d required 1 run len 07 dir 0", run_len.size());
    end
    checks++;
    if (outs.size() != 8) begin
      errors++;
      $display("FAIL rd_count: got %0d required 8", outs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (outs[i] !== ((32'h200 + 32'(4 * i)) ^ 32'h5A5A_0000)) begin
          errors++;
          $display("FAIL rd_data%0d: got %h required %h", i, outs[i],
                   (32'h200 + 32'(4 * i)) ^ 32'h5A5A_0000);
        end
      end
    end
    checks++;
    if (bp_bad != 0 || stall_seen == 0) begin
      errors++;
      $display("FAIL rd_backpressure: got m_valid_while_full=%0d stalls=%0d required 0/>0",
               bp_bad, stall_seen);
    end
    checks++;
    if (beat_strb.size() != 8 || beat_strb[0] !== 4'h0 || beat_strb[7] !== 4'h0
        || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_strb_drain: got beats=%0d out_valid=%b required 8 zero-strobe/0",
               beat_strb.size(), out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_write_stall();
    int s;
    int stalls;
    logic [31:0] w0;
    clear_mon();
    stalls = 0;
    in_valid = 1'b1; iob_ready = 1'b1;
    w0 = wcnt;
    do_start(1'b1, 32'h300, 16'd6, s);
    for (int i = 0; i < 60; i++) begin
      if (beat_addr.size() == 2 && stalls < 5) begin
        in_valid = 1'b0;
        stalls++;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_addr !== 32'h308) begin
          errors++;
          $display("FAIL stall_hold: got m_valid=%b addr=%h required 0/308", m_valid, m_addr);
        end
      end else begin
        in_valid = 1'b1;
      end
      @(negedge clk);
      #1;
      if (done_cnt > 0) break;
      step();
    end
    checks++;
    if (done_cnt != 1 || stalls != 5) begin
      errors++;
      $display("FAIL stall_done: got done=%0d stalls=%0d required 1/5", done_cnt, stalls);
    end
    checks++;
    if (beat_addr.size() != 6 || run_beats.size() != 1 || run_beats[0] != 6) begin
      errors++;
      $display("FAIL stall_beats: got %0d required 6", beat_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (beat_addr[i] !== 32'h300 + 32'(4 * i) || beat_data[i] !== 32'hD000_0000 + w0 + 32'(i)) begin
          errors++;
          $display("FAIL stall_beat%0d: got %h/%h required %h/%h", i, beat_addr[i],
                   beat_data[i], 32'h300 + 32'(4 * i), 32'hD000_0000 + w0 + 32'(i));
        end
      end
      checks++;
      if (beat_cyc[2] - beat_cyc[1] != 6) begin
        errors++;
        $display("FAIL stall_gap: got %0d required 6", beat_cyc[2] - beat_cyc[1]);
      end
    end
  endtask

  task automatic test_edge_cases();
    int s;
    // Zero-length descriptor.
    clear_mon();
    do_start(1'b1, 32'h0, 16'd0, s);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b required 1/0", done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || run_len.size() != 0) begin
      errors++;
      $display("FAIL zero_pulse: got done=%b runs=%0d required 0/0", done, run_len.size());
    end
    // Start while busy is ignored; iob_error is sticky.
    clear_mon();
    in_valid = 1'b1;
    do_start(1'b1, 32'h400, 16'd4, s);
    step();
    start = 1'b1; addr = 32'h800; nwords = 16'd2; dir = 1'b0;
    step();
    start = 1'b0; iob_error = 1'b1;
    step();
    iob_error = 1'b0;
    wait_done(50, 1'b0, "busy_start");
    checks++;
    if (beat_addr.size() != 4 || run_len.size() != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start: got beats=%0d runs=%0d done=%0d required 4/1/1",
               beat_addr.size(), run_len.size(), done_cnt);
    end else begin
      checks++;
      if (beat_addr[0] !== 32'h400 || beat_addr[3] !== 32'h40C) begin
        errors++;
        $display("FAIL busy_start_addr: got %h..%h required 400..40c", beat_addr[0], beat_addr[3]);
      end
    end
    step(); step();
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: got %b required 1", error);
    end
    do_start(1'b1, 32'h0, 16'd0, s);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got %b required 0", error);
    end
    // Reset in the middle of a burst.
    clear_mon();
    do_start(1'b1, 32'h500, 16'd8, s);
    iob_error = 1'b1;
    step();
    iob_error = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({busy, done, error, iob_run, iob_direction, m_valid, in_ready, out_valid} !== 8'h00
        || iob_length !== 8'd0 || m_addr !== 32'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_xfer: got ctrl=%b len=%h addr=%h data=%h required all zero",
               {busy, done, error, iob_run, iob_direction, m_valid, in_ready, out_valid},
               iob_length, m_addr, out_data);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || iob_run !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got busy=%b m_valid=%b run=%b required 0/0/0",
               busy, m_valid, iob_run);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_write_single();
    test_multi_burst();
    test_read_backpressure();
    test_write_stall();
    test_edge_cases();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
